gm_port_arbiter: RTL and testbench



---
 rtl/gm_port_arbiter.sv | 172 +++++++++++++++++
 tb/tb_gm_port_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gm_port_arbiter.sv
// Shares graphics-RAM port A between CPU accesses and a clear/scroll-up engine.
// Latency: CPU grant -> ack 1 cycle; mem_* outputs are combinational from the grant.
// Backpressure: CPU wins any cycle it is not being acked; engine stalls until granted.
module gm_port_arbiter #(
    parameter int              COLS       = 80,
    parameter int              ROWS       = 60,
    parameter int              ADDR_WIDTH = 13,
    parameter logic [7:0]      BLANK      = 8'h20
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  cpu_req_i,
    input  logic                  cpu_we_i,
    input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
    input  logic [7:0]            cpu_data_i,
    output logic                  cpu_ack_o,
    output logic [7:0]            cpu_data_o,
    input  logic                  cmd_clear_i,
    input  logic                  cmd_scroll_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [7:0]            mem_data_o,
    output logic                  mem_wren_o,
    input  logic [7:0]            mem_data_i
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(COLS * ROWS - 1);
    localparam logic [ADDR_WIDTH-1:0] FILL_BASE = ADDR_WIDTH'(COLS * (ROWS - 1));
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP  = ADDR_WIDTH'(COLS);
    localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COPY_RD,
        ST_COPY_WR,
        ST_FILL,
        ST_FINISH
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] src;
    logic [ADDR_WIDTH-1:0] dst;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [7:0]            hold;
    logic                  copy_first;
    logic                  cpu_rd_q;

    logic                  cpu_grant;
    logic                  eng_need;
    logic                  eng_grant;
    logic [ADDR_WIDTH-1:0] eng_addr;
    logic [7:0]            eng_data;
    logic                  eng_we;

    // Grant logic is gated by reset so the port stays quiet while rst_n_i is low.
    always_comb begin
        cpu_grant = rst_n_i && cpu_req_i && !cpu_ack_o;
        eng_need  = (state == ST_COPY_RD) || (state == ST_COPY_WR) || (state == ST_FILL);
        eng_grant = rst_n_i && eng_need && !cpu_grant;

        eng_addr = '0;
        eng_data = 8'h00;
        eng_we   = 1'b0;
        case (state)
            ST_COPY_RD: begin
                eng_addr = src;
            end
            ST_COPY_WR: begin
                // On the first COPY_WR cycle the read data is still on the bus, not yet in hold.
                eng_addr = dst;
                eng_data = copy_first ? mem_data_i : hold;
                eng_we   = 1'b1;
            end
            ST_FILL: begin
                eng_addr = ptr;
                eng_data = BLANK;
                eng_we   = 1'b1;
            end
            default: ;
        endcase

        mem_addr_o = '0;
        mem_data_o = 8'h00;
        mem_wren_o = 1'b0;
        if (cpu_grant) begin
            mem_addr_o = cpu_addr_i;
            mem_data_o = cpu_data_i;
            mem_wren_o = cpu_we_i;
        end else if (eng_grant) begin
            mem_addr_o = eng_addr;
            mem_data_o = eng_data;
            mem_wren_o = eng_we;
        end
    end

    assign cpu_data_o = (cpu_ack_o && cpu_rd_q) ? mem_data_i : 8'h00;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state      <= ST_IDLE;
            src        <= '0;
            dst        <= '0;
            ptr        <= '0;
            hold       <= 8'h00;
            copy_first <= 1'b0;
            cpu_rd_q   <= 1'b0;
            cpu_ack_o  <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            cpu_ack_o  <= cpu_grant;
            cpu_rd_q   <= cpu_grant && !cpu_we_i;
            done_o     <= 1'b0;
            copy_first <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_clear_i) begin
                        state  <= ST_FILL;
                        ptr    <= '0;
                        busy_o <= 1'b1;
                    end else if (cmd_scroll_i) begin
                        state  <= ST_COPY_RD;
                        src    <= ROW_STEP;
                        dst    <= '0;
                        busy_o <= 1'b1;
                    end
                end
                ST_COPY_RD: begin
                    if (eng_grant) begin
                        state      <= ST_COPY_WR;
                        copy_first <= 1'b1;
                    end
                end
                ST_COPY_WR: begin
                    if (copy_first) begin
                        hold <= mem_data_i;
                    end
                    if (eng_grant) begin
                        dst <= dst + ONE;
                        if ((dst + ONE) == FILL_BASE) begin
                            state <= ST_FILL;
                            ptr   <= FILL_BASE;
                        end else begin
                            state <= ST_COPY_RD;
                            src   <= src + ONE;
                        end
                    end
                end
                ST_FILL: begin
                    if (eng_grant) begin
                        if (ptr == LAST_ADDR) begin
                            state <= ST_FINISH;
                        end else begin
                            ptr <= ptr + ONE;
                        end
                    end
                end
                ST_FINISH: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                    done_o <= 1'b1;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gm_port_arbiter.sv
// Bench for gm_port_arbiter: RAM model on port A, random CPU traffic, engine scenarios.
module tb_gm_port_arbiter;
    localparam int AW    = 13;
    localparam int CELLS = 4800;
    localparam int COLS  = 80;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [7:0]    cpu_wdata = 8'h00;
    logic          cpu_ack;
    logic [7:0]    cpu_rdata;
    logic          cmd_clear = 1'b0, cmd_scroll = 1'b0;
    logic          busy, done;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_wren;
    logic [7:0]    mem_rdata = 8'h00;

    logic [7:0] ram   [0:8191];
    logic [7:0] model [0:CELLS-1];

    int n_cmp = 0;
    int n_err = 0;
    int done_pulses = 0;
    int oob_writes = 0;
    int rst_writes = 0;

    always #5 clk = ~clk;

    gm_port_arbiter dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_data_i(cpu_wdata),
        .cpu_ack_o(cpu_ack), .cpu_data_o(cpu_rdata),
        .cmd_clear_i(cmd_clear), .cmd_scroll_i(cmd_scroll),
        .busy_o(busy), .done_o(done),
        .mem_addr_o(mem_addr), .mem_data_o(mem_wdata), .mem_wren_o(mem_wren),
        .mem_data_i(mem_rdata)
    );

    // Synchronous-read RAM: read returns the pre-write contents.
    always @(posedge clk) begin
        mem_rdata <= ram[mem_addr];
        if (mem_wren) ram[mem_addr] = mem_wdata;
    end

    always @(negedge clk) begin
        if (done) done_pulses++;
        if (mem_wren && mem_addr >= AW'(CELLS)) oob_writes++;
        if (!rst_n && mem_wren) rst_writes++;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic preload(input bit rnd);
        logic [7:0] v;
        for (int i = 0; i < 8192; i++) begin
            if (i < CELLS) v = rnd ? 8'($urandom) : 8'(i);
            else v = 8'hEE;
            ram[i] = v;
            if (i < CELLS) model[i] = v;
        end
    endtask

    task automatic expect_clear;
        for (int i = 0; i < CELLS; i++) model[i] = 8'h20;
    endtask

    task automatic expect_scroll;
        for (int i = 0; i < CELLS; i++) model[i] = (i < CELLS - COLS) ? model[i + COLS] : 8'h20;
    endtask

    task automatic check_mem(input string name);
        int bad = 0, first = -1, sbad = 0;
        for (int i = 0; i < CELLS; i++)
            if (ram[i] !== model[i]) begin bad++; if (first < 0) first = i; end
        for (int i = CELLS; i < 8192; i++) if (ram[i] !== 8'hEE) sbad++;
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL %s_mem: %0d bad cells, first addr %0d got %h required %h",
                     name, bad, first, ram[first], model[first]);
        end
        n_cmp++;
        if (sbad != 0 || oob_writes != 0) begin
            n_err++;
            $display("FAIL %s_range: %0d cells beyond 4799 touched, %0d oob writes, required 0",
                     name, sbad, oob_writes);
        end
    endtask

    task automatic cpu_access(input logic we, input logic [AW-1:0] a, input logic [7:0] d,
                              output logic [7:0] q, output int lat);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!cpu_ack && lat < 50);
        q = cpu_rdata;
        cpu_req = 1'b0;
    endtask

    task automatic run_engine(input logic clr, input logic scr, input int inject_at,
                              output int busy_cycles);
        int p0;
        p0 = done_pulses;
        @(negedge clk);
        cmd_clear = clr; cmd_scroll = scr;
        @(negedge clk);
        cmd_clear = 1'b0; cmd_scroll = 1'b0;
        busy_cycles = 0;
        while (busy && busy_cycles < 30000) begin
            cmd_scroll = (busy_cycles == inject_at);
            busy_cycles++;
            @(negedge clk);
        end
        cmd_scroll = 1'b0;
        n_cmp++;
        if (busy) begin n_err++; $display("FAIL engine_timeout: busy still 1 after %0d cycles, required 0", busy_cycles); end
        n_cmp++;
        if (done !== 1'b1) begin n_err++; $display("FAIL done_at_end: done=%b, required 1", done); end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin n_err++; $display("FAIL done_width: done=%b, required 0", done); end
        n_cmp++;
        if (done_pulses - p0 != 1) begin
            n_err++; $display("FAIL done_count: %0d pulses, required 1", done_pulses - p0);
        end
    endtask

    task automatic test_reset;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c > 0) begin
                n_cmp++;
                if ({cpu_ack, cpu_rdata, busy, done, mem_wren, mem_addr, mem_wdata} !== '0) begin
                    n_err++;
                    $display("FAIL reset_outputs: ack=%b rd=%h busy=%b done=%b wren=%b addr=%0d wd=%h, required all 0",
                             cpu_ack, cpu_rdata, busy, done, mem_wren, mem_addr, mem_wdata);
                end
            end
            cpu_req = 1'($urandom); cpu_we = 1'($urandom); cpu_addr = AW'($urandom);
            cpu_wdata = 8'($urandom); cmd_clear = 1'($urandom); cmd_scroll = 1'($urandom);
        end
        n_cmp++;
        if (rst_writes != 0) begin n_err++; $display("FAIL reset_wren: %0d writes in reset, required 0", rst_writes); end
        cpu_req = 1'b0; cpu_we = 1'b0; cmd_clear = 1'b0; cmd_scroll = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_cpu_idle;
        logic [7:0] q;
        logic [AW-1:0] a;
        int lat;
        preload(1);
        cpu_access(1'b1, AW'(100), 8'hA5, q, lat);
        n_cmp++;
        if (lat != 1) begin n_err++; $display("FAIL cpu_wr_latency: %0d cycles, required 1", lat); end
        cpu_access(1'b0, AW'(100), 8'h00, q, lat);
        n_cmp++;
        if (lat != 1) begin n_err++; $display("FAIL cpu_rd_latency: %0d cycles, required 1", lat); end
        n_cmp++;
        if (q !== 8'hA5) begin n_err++; $display("FAIL cpu_rd_data: got %h, required a5", q); end
        model[100] = 8'hA5;
        for (int k = 0; k < 12; k++) begin
            a = AW'($urandom_range(0, CELLS - 1));
            if ($urandom_range(0, 1) == 1) begin
                model[a] = 8'($urandom);
                cpu_access(1'b1, a, model[a], q, lat);
            end else begin
                cpu_access(1'b0, a, 8'h00, q, lat);
                n_cmp++;
                if (q !== model[a]) begin n_err++; $display("FAIL cpu_rand_rd: addr %0d got %h required %h", a, q, model[a]); end
            end
            n_cmp++;
            if (lat != 1) begin n_err++; $display("FAIL cpu_rand_latency: %0d cycles, required 1", lat); end
        end
        check_mem("cpu_idle");
    endtask

    task automatic test_clear;
        int bc;
        preload(0);
        run_engine(1'b1, 1'b0, -1, bc);
        n_cmp++;
        if (bc != 4801) begin n_err++; $display("FAIL clear_busy: %0d cycles, required 4801", bc); end
        expect_clear();
        check_mem("clear");
    endtask

    task automatic test_scroll;
        int bc;
        preload(0);
        run_engine(1'b0, 1'b1, -1, bc);
        n_cmp++;
        if (bc != 9521) begin n_err++; $display("FAIL scroll_busy: %0d cycles, required 9521", bc); end
        n_cmp++;
        if (ram[0] !== 8'h50 || ram[4719] !== 8'hBF || ram[4720] !== 8'h20) begin
            n_err++;
            $display("FAIL scroll_corners: mem0=%h mem4719=%h mem4720=%h, required 50 bf 20", ram[0], ram[4719], ram[4720]);
        end
        expect_scroll();
        check_mem("scroll");
    endtask

    task automatic test_contention;
        int bc, gap, bad_gap, nacks, lat;
        logic stop;
        logic [7:0] q;
        preload(0);
        expect_scroll();
        fork
            run_engine(1'b0, 1'b1, -1, bc);
            begin
                @(negedge clk);
                cpu_we = 1'b0; cpu_addr = AW'(4799); cpu_req = 1'b1;
                gap = 0; bad_gap = 0; nacks = 0; stop = 1'b0;
                for (int c = 0; c < 25000 && !stop; c++) begin
                    @(negedge clk);
                    gap++;
                    if (cpu_ack) begin
                        if (nacks > 0 && gap != 2) bad_gap++;
                        nacks++;
                        gap = 0;
                        if (!busy) stop = 1'b1;
                    end
                end
                cpu_req = 1'b0;
            end
        join
        n_cmp++;
        if (bad_gap != 0 || nacks < 9000) begin
            n_err++; $display("FAIL contention_ack_rate: %0d acks, %0d bad gaps, required >=9000 acks every 2 cycles", nacks, bad_gap);
        end
        n_cmp++;
        if (bc < 9521 || bc > 19042) begin n_err++; $display("FAIL contention_busy: %0d cycles, required 9521..19042", bc); end
        check_mem("contention");
        cpu_access(1'b0, AW'(4799), 8'h00, q, lat);
        n_cmp++;
        if (q !== 8'h20 || lat != 1) begin n_err++; $display("FAIL contention_final_rd: got %h lat %0d, required 20 lat 1", q, lat); end
    endtask

    task automatic test_random_contention;
        int bc, lat, bad_lat, n;
        logic [7:0] q;
        preload(1);
        expect_scroll();
        fork
            run_engine(1'b0, 1'b1, -1, bc);
            begin
                bad_lat = 0; n = 0;
                repeat (2) @(negedge clk);
                while (busy && n < 6000) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    cpu_access(1'b0, AW'($urandom_range(0, CELLS - 1)), 8'h00, q, lat);
                    if (lat != 1) bad_lat++;
                    n++;
                end
            end
        join
        n_cmp++;
        if (bad_lat != 0 || n == 0) begin n_err++; $display("FAIL rand_cpu_latency: %0d of %0d late, required 0", bad_lat, n); end
        check_mem("rand_scroll");
    endtask

    task automatic test_reset_mid;
        int p0;
        preload(0);
        p0 = done_pulses;
        @(negedge clk); cmd_scroll = 1'b1;
        @(negedge clk); cmd_scroll = 1'b0;
        repeat ($urandom_range(100, 2000)) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL midreset_pre_busy: busy=%b, required 1", busy); end
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || mem_wren !== 1'b0) begin
            n_err++; $display("FAIL midreset_busy: busy=%b wren=%b, required 0 0", busy, mem_wren);
        end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done_pulses != p0) begin
            n_err++; $display("FAIL midreset_done: busy=%b done pulses %0d, required 0 0", busy, done_pulses - p0);
        end
    endtask

    task automatic test_collisions;
        int bc;
        preload(1);
        run_engine(1'b1, 1'b1, -1, bc);
        n_cmp++;
        if (bc != 4801) begin n_err++; $display("FAIL both_cmds_busy: %0d cycles, required 4801", bc); end
        expect_clear();
        check_mem("both_cmds");
        preload(1);
        run_engine(1'b1, 1'b0, 1000, bc);
        n_cmp++;
        if (bc != 4801) begin n_err++; $display("FAIL cmd_while_busy: %0d cycles, required 4801", bc); end
        expect_clear();
        check_mem("cmd_while_busy");
    endtask

    initial begin
        test_reset();
        test_cpu_idle();
        test_clear();
        test_scroll();
        test_contention();
        test_random_contention();
        test_reset_mid();
        test_collisions();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
